// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared constants and helpers for the divider bank
package divider_pkg;

   // Default divisor loaded into every channel at reset
   localparam int DIV_RESET_DEFAULT = 25000000;

   // Default counter and divisor width in bits
   localparam int N_DEFAULT = 27;

   // Largest supported channel count
   localparam int CHANNELS_MAX = 16;

   // Width of the channel select bus: clog2 with a floor of one bit
   function automatic int sel_width(input int channels);
      return (channels <= 2) ? 1 : $clog2(channels);
   endfunction

endpackage

// File: rtl/divider_channel.sv
// rtl/divider_channel.sv - one divider channel; tick output gated by DIVIDER_TICK_EN
module divider_channel
   import divider_pkg::*;
#(
   parameter int N         = N_DEFAULT,
   parameter int DIV_RESET = DIV_RESET_DEFAULT
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   input  logic         load_i,
   input  logic [N-1:0] data_i,
   output logic         pend_o,
   output logic         out_o
`ifdef DIVIDER_TICK_EN
   ,output logic        tick_o
`endif
);

   logic [N-1:0] cnt_q,  cnt_d;
   logic [N-1:0] div_q,  div_d;
   logic [N-1:0] pdiv_q, pdiv_d;
   logic         pend_q, pend_d;
   logic         out_q,  out_d;
   logic         tick_d;
   logic         term;

   // A terminal count only happens on an edge where the channel is enabled
   assign term = en_i && (cnt_q == div_q);

   // Next-state: count, toggle at terminal count, apply pending divisor when safe
   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      pdiv_d = pdiv_q;
      pend_d = pend_q;
      out_d  = out_q;
      tick_d = 1'b0;

      if (en_i) begin
         if (term) begin
            // New half-period starts here, so a pending divisor can swap in glitch-free
            cnt_d  = '0;
            out_d  = ~out_q;
            tick_d = 1'b1;
            if (pend_q) begin
               div_d  = pdiv_q;
               pend_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (pend_q) begin
         // Stopped channel: nothing to glitch, apply at once and restart the count
         div_d  = pdiv_q;
         cnt_d  = '0;
         pend_d = 1'b0;
      end

      // A load on this edge always lands in the pending slot; the apply above used the old one
      if (load_i) begin
         pdiv_d = data_i;
         pend_d = 1'b1;
      end
   end

   // State register with asynchronous reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q  <= '0;
         div_q  <= N'(DIV_RESET);
         pdiv_q <= '0;
         pend_q <= 1'b0;
         out_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         pdiv_q <= pdiv_d;
         pend_q <= pend_d;
         out_q  <= out_d;
      end
   end

`ifdef DIVIDER_TICK_EN
   logic tick_q;

   // Tick strobe register, high for the first cycle of each new out level
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;
`else
   logic unused_tick;
   assign unused_tick = tick_d;
`endif

   assign pend_o = pend_q;
   assign out_o  = out_q;

endmodule

// File: rtl/divider_bank.sv
// rtl/divider_bank.sv - multi-channel programmable clock divider; tick port gated by DIVIDER_TICK_EN
module divider_bank
   import divider_pkg::*;
#(
   parameter int CHANNELS  = 4,
   parameter int N         = N_DEFAULT,
   parameter int DIV_RESET = DIV_RESET_DEFAULT
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [CHANNELS-1:0]            en_i,
   input  logic                           div_load_i,
   input  logic [sel_width(CHANNELS)-1:0] div_sel_i,
   input  logic [N-1:0]                   div_data_i,
   output logic [CHANNELS-1:0]            pend_o,
   output logic [CHANNELS-1:0]            out_o
`ifdef DIVIDER_TICK_EN
   ,output logic [CHANNELS-1:0]           tick_o
`endif
);

   localparam int SW = sel_width(CHANNELS);

   logic                sel_in_range;
   logic [CHANNELS-1:0] load_vec;

   // Selects past the last channel exist only for non-power-of-two counts and are dropped
   assign sel_in_range = int'(div_sel_i) < CHANNELS;

   // One-hot decode of the load strobe onto the addressed channel
   always_comb begin
      load_vec = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (div_load_i && sel_in_range && (div_sel_i == SW'(i))) begin
            load_vec[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      divider_channel #(
         .N         (N),
         .DIV_RESET (DIV_RESET)
      ) u_ch (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .en_i   (en_i[g]),
         .load_i (load_vec[g]),
         .data_i (div_data_i),
         .pend_o (pend_o[g]),
         .out_o  (out_o[g])
`ifdef DIVIDER_TICK_EN
         ,.tick_o (tick_o[g])
`endif
      );
   end

endmodule

// File: tb/tb_divider_bank.sv
// tb/tb_divider_bank.sv - directed self-checking bench for divider_bank (tick checks under DIVIDER_TICK_EN)
module tb_divider_bank;

   localparam int CH = 3;
   localparam int NW = 8;
   localparam int DR = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [CH-1:0] en;
   logic          div_load;
   logic [1:0]    div_sel;
   logic [NW-1:0] div_data;
   logic [CH-1:0] pend;
   logic [CH-1:0] out;
`ifdef DIVIDER_TICK_EN
   logic [CH-1:0] tick;
`endif

   int n_vec = 0;
   int n_err = 0;

   divider_bank #(
      .CHANNELS  (CH),
      .N         (NW),
      .DIV_RESET (DR)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .en_i       (en),
      .div_load_i (div_load),
      .div_sel_i  (div_sel),
      .div_data_i (div_data),
      .pend_o     (pend),
      .out_o      (out)
`ifdef DIVIDER_TICK_EN
      ,.tick_o    (tick)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance n rising edges, then sit 1 time unit past the last one
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1:0] sel, input logic [NW-1:0] data);
      div_load = 1'b1;
      div_sel  = sel;
      div_data = data;
      cyc(1);
      div_load = 1'b0;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      en       = '0;
      div_load = 1'b0;
      cyc(2);
      rst      = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      en       = '0;
      div_load = 1'b0;
      div_sel  = '0;
      div_data = '0;
      cyc(2);
      check_val("rst_out", 32'(out), 32'h0);
      check_val("rst_pend", 32'(pend), 32'h0);
`ifdef DIVIDER_TICK_EN
      check_val("rst_tick", 32'(tick), 32'h0);
`endif

      // basic timing with DIV_RESET=3 on channel 0
      rst = 1'b0;
      en  = 3'b001;
      cyc(3);
      check_val("pre_rise", 32'(out), 32'h0);
      cyc(1);
      check_val("rise_e4", 32'(out), 32'h1);
`ifdef DIVIDER_TICK_EN
      check_val("tick_e4", 32'(tick), 32'h1);
`endif
      cyc(1);
`ifdef DIVIDER_TICK_EN
      check_val("tick_e5", 32'(tick), 32'h0);
`endif
      cyc(2);
      check_val("hold_e7", 32'(out), 32'h1);
      cyc(1);
      check_val("fall_e8", 32'(out), 32'h0);
`ifdef DIVIDER_TICK_EN
      check_val("tick_e8", 32'(tick), 32'h1);
`endif

      // div=0 on disabled channel 1, then enable it
      do_reset();
      load(2'd1, 8'd0);
      check_val("d0_pend", 32'(pend), 32'h2);
      cyc(1);
      check_val("d0_apply", 32'(pend), 32'h0);
      en = 3'b010;
      cyc(1);
      check_val("d0_t1", 32'(out), 32'h2);
      cyc(1);
      check_val("d0_t2", 32'(out), 32'h0);
`ifdef DIVIDER_TICK_EN
      check_val("d0_tick2", 32'(tick), 32'h2);
`endif
      cyc(1);
      check_val("d0_t3", 32'(out), 32'h2);
`ifdef DIVIDER_TICK_EN
      check_val("d0_tick3", 32'(tick), 32'h2);
`endif
      // disable: output holds
      en = 3'b000;
      cyc(3);
      check_val("d0_hold", 32'(out), 32'h2);

      // channel 0 at div=9, reload to 1 while cnt=2
      do_reset();
      load(2'd0, 8'd9);
      cyc(1);
      en = 3'b001;
      cyc(2);
      load(2'd0, 8'd1);
      check_val("rl_pend", 32'(pend), 32'h1);
      cyc(6);
      check_val("rl_old_e11", 32'(out), 32'h0);
      check_val("rl_pend_e11", 32'(pend), 32'h1);
      cyc(1);
      check_val("rl_tog_e12", 32'(out), 32'h1);
      check_val("rl_clr_e12", 32'(pend), 32'h0);
      cyc(1);
      check_val("rl_e13", 32'(out), 32'h1);
      cyc(1);
      check_val("rl_e14", 32'(out), 32'h0);
      cyc(2);
      check_val("rl_e16", 32'(out), 32'h1);

      // disabled channel 2: load 5, applies next edge, enable gives toggle after 6 edges
      do_reset();
      load(2'd2, 8'd5);
      check_val("dis_pend", 32'(pend), 32'h4);
      cyc(1);
      check_val("dis_apply", 32'(pend), 32'h0);
      en = 3'b100;
      cyc(5);
      check_val("dis_pre", 32'(out), 32'h0);
      cyc(1);
      check_val("dis_tog", 32'(out), 32'h4);

      // out-of-range select is ignored
      do_reset();
      load(2'd3, 8'd0);
      check_val("oor_pend", 32'(pend), 32'h0);
      en = 3'b111;
      cyc(3);
      check_val("oor_pre", 32'(out), 32'h0);
      cyc(1);
      check_val("oor_tog", 32'(out), 32'h7);

      // load on the terminal-count edge: old divisor runs one more half-period
      cyc(3);
      load(2'd0, 8'd1);
      check_val("co_out", 32'(out), 32'h0);
      check_val("co_pend", 32'(pend), 32'h1);
      cyc(3);
      check_val("co_hold", 32'(out), 32'h0);
      check_val("co_pend2", 32'(pend), 32'h1);
      cyc(1);
      check_val("co_tog", 32'(out), 32'h7);
      check_val("co_clr", 32'(pend), 32'h0);
      cyc(2);
      check_val("co_new", 32'(out), 32'h6);

      // async reset mid-period with a pending load
      load(2'd1, 8'd7);
      check_val("ar_pend", 32'(pend), 32'h2);
      #2;
      rst = 1'b1;
      #1;
      check_val("ar_out", 32'(out), 32'h0);
      check_val("ar_pend0", 32'(pend), 32'h0);
`ifdef DIVIDER_TICK_EN
      check_val("ar_tick", 32'(tick), 32'h0);
`endif
      cyc(1);
      rst = 1'b0;
      cyc(3);
      check_val("ar_pre", 32'(out), 32'h0);
      cyc(1);
      check_val("ar_tog", 32'(out), 32'h7);
      check_val("ar_nopend", 32'(pend), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/divider_bank.md
# divider_bank

Multi-channel programmable clock divider: the parametrised successor to the team's single fixed-ratio lowering counter. It generates CHANNELS independent square waves from one fast clock, each with its own runtime-loadable divisor and per-channel enable. Each channel also produces an optional single-cycle tick strobe. Divisor updates are deferred to a terminal count so outputs never glitch. It sits between the board clock and slow consumers such as LED blinkers, display multiplexers and sequencer step timers.

## Interface
Parameters:
- CHANNELS, 4 — number of independent divider channels (1..16)
- N, 27 — counter and divisor width in bits
- DIV_RESET, 25000000 — divisor loaded into every channel at reset; must fit in N bits

Ports:
- in  input  1  clock (all logic on its rising edge)
- rst  input  1  asynchronous, active-high reset
- en  input  CHANNELS  per-channel run enable
- div_load  input  1  one-cycle strobe: capture div_data for channel div_sel
- div_sel  input  $clog2(CHANNELS) (min 1)  target channel of div_load
- div_data  input  N  new divisor value
- pend  output  CHANNELS  per-channel flag: loaded divisor not yet applied
- out  output  CHANNELS  divided clock outputs
- tick  output  CHANNELS  one-cycle strobe on every out toggle (only with DIVIDER_TICK_EN)

## Operation
- Reset (async, immediate): cnt=0, div=DIV_RESET, pending register=0, pend=0, out=0, tick=0, for all channels.
- Running channel (en[i]=1): cnt increments each cycle. When cnt==div: cnt<=0, out[i]<=~out[i], tick[i]<=1. tick is 0 on all other cycles.
- Half-period is div+1 cycles, so the out period is 2*(div+1). div=0 gives in/2, and tick is then high every cycle.
- Disabled channel (en[i]=0): cnt and out hold, tick=0. Re-enabling resumes from the held count without restarting.
- Load: div_load=1 writes div_data into channel div_sel's pending register and sets pend[div_sel]=1. A load while pend is already set overwrites the pending value; last write wins.
- div_sel>=CHANNELS (non-power-of-two CHANNELS): the load is ignored and no pend bit changes.
- Apply, running channel: at the next terminal-count edge, div<=pending value and pend clears. The new half-period starts at that edge.
- Apply, disabled channel: applied on the next edge after the load. cnt<=0, pend clears, out is unchanged.
- Load and terminal count at the same edge on the same channel:
  - the terminal count uses the old pending state (applies it if pend was set, else keeps div);
  - the new value becomes pending and applies at the following terminal count.
- Counter width: cnt is N bits and never exceeds div, because div changes only when cnt resets to 0.
- Channels are fully independent; a load to one channel never affects another.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- out and tick change on the same edge. tick is high for exactly the first cycle of each new out level.
- Load-to-pend latency: 1 cycle.
- Load-to-effect latency: up to div_old+1 cycles for a running channel; 1 cycle for a disabled channel.
- en change takes effect on the edge where it is sampled: a terminal count on that edge happens only if en=1.
- Reset mid-period discards the count and any pending load. The first toggle after reset release is at edge DIV_RESET+1 from release, with en held high.

## Configuration
- Macro DIVIDER_TICK_EN.
- Defined: tick port exists and behaves as above.
- Undefined: tick port and its registers are removed; out and pend are unaffected.

## Structure
- Package divider_pkg: default constants (DIV_RESET, default N, CHANNELS limit) and a function computing the div_sel width (clog2 with minimum 1).
- Sub-module divider_channel, instantiated per channel via generate: holds cnt, div, pending register, pend, out and tick, and takes a decoded per-channel load strobe.
- divider_bank itself contains only the div_sel decode, the range check and the generate loop.

## Test plan
- Reset, then en=4'b0001, DIV_RESET=3 → out[0] rises at cycle 4, falls at cycle 8, period 8; tick[0] pulses at cycles 4 and 8; other channels stay 0.
- div=0 on channel 1, enabled → out[1] toggles every cycle and tick[1] stays high.
- Channel 0 running with div=9; at cnt=2 load div_data=1 → pend[0]=1 next cycle; old half-period completes (10 cycles); pend clears at that edge; next half-periods are 2 cycles.
- Channel 2 disabled, load 5 → pend[2]=1 then cleared next cycle with cnt=0. Enable → first toggle after 6 cycles.
- CHANNELS=3, div_sel=3 load → no pend bit set, all periods unchanged. Load coinciding with terminal count → old divisor kept for one more half-period, new one after.
- Assert rst mid-period with a pending load → all outputs 0 and pend=0 immediately, without waiting for a clock edge; after release the period is again based on DIV_RESET.
